// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared types and ALU function for the accumulator and its command sequencer
package acc_pkg;

  localparam int ACC_W = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_OR  = 2'd2,
    OP_XOR = 2'd3
  } op_t;

  typedef struct packed {
    op_t              op;
    logic [ACC_W-1:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Accumulator update; wraps modulo 2^ACC_W, carries and borrows are dropped.
  function automatic logic [ACC_W-1:0] acc_apply(input logic [ACC_W-1:0] acc,
                                                 input op_t op,
                                                 input logic [ACC_W-1:0] data);
    logic [ACC_W-1:0] res;
    case (op)
      OP_ADD:  res = acc + data;
      OP_SUB:  res = acc - data;
      OP_OR:   res = acc | data;
      default: res = acc ^ data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/acc_cmd_mem.sv
// rtl/acc_cmd_mem.sv - program store: flop array with one write port and one registered read port
module acc_cmd_mem
  import acc_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  cmd_t          wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output cmd_t          rd_data
);

  cmd_t mem_q [DEPTH];

  // Storage array carries no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Read register only updates when the sequencer fetches, so the payload holds while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem_q[rd_addr];
  end

endmodule

// File: rtl/acc_cmd_sequencer.sv
// rtl/acc_cmd_sequencer.sv - loads a command program, replays it to the accumulator and checks results
module acc_cmd_sequencer
  import acc_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = ACC_W,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              load_valid,
  input  logic [1:0]        load_op,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              start,
  input  logic              clear,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd_op,
  output logic [DATA_W-1:0] cmd_data,
  input  logic [DATA_W-1:0] acc_in,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [CW-1:0]     count
);

  state_t            state;
  logic [CW-1:0]     rd_ptr;
  logic [DATA_W-1:0] expected;
  logic              load_fire;
  logic              launch;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  cmd_t              wr_cmd;
  cmd_t              rd_cmd;

  // clear takes precedence over a same-cycle load, so the load is not offered.
  assign load_ready = (state == ST_IDLE) && ena && (count < CW'(DEPTH)) && !clear;
  assign load_fire  = load_valid && load_ready;

  // Playback begins from IDLE with a non-empty program, or as a replay from DONE.
  assign launch = start && ena && !clear &&
                  (((state == ST_IDLE) && (count != '0)) || (state == ST_DONE));

  // Fetch entry 0 on launch, and the next entry during CHECK when one remains.
  assign rd_en   = launch || ((state == ST_CHECK) && (rd_ptr != count));
  assign rd_addr = launch ? '0 : rd_ptr[AW-1:0];

  assign wr_cmd = '{op: op_t'(load_op), data: load_data};

  acc_cmd_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (load_fire),
    .wr_addr (count[AW-1:0]),
    .wr_data (wr_cmd),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_cmd)
  );

  assign cmd_valid = (state == ST_PLAY);
  assign cmd_op    = rd_cmd.op;
  assign cmd_data  = rd_cmd.data;
  assign busy      = (state == ST_PLAY) || (state == ST_CHECK);
  assign done      = (state == ST_DONE);

  // Sequencer state, program length, replay pointer and golden accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      count    <= '0;
      rd_ptr   <= '0;
      expected <= '0;
      mismatch <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clear) begin
            count    <= '0;
            mismatch <= 1'b0;
          end else begin
            if (load_fire) count <= count + 1'b1;
            if (launch) begin
              state    <= ST_PLAY;
              rd_ptr   <= '0;
              expected <= '0;
              mismatch <= 1'b0;
            end
          end
        end
        ST_PLAY: begin
          if (cmd_ready) begin
            expected <= acc_apply(expected, rd_cmd.op, rd_cmd.data);
            rd_ptr   <= rd_ptr + 1'b1;
            state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (acc_in != expected) mismatch <= 1'b1;
          state <= (rd_ptr == count) ? ST_DONE : ST_PLAY;
        end
        default: begin
          if (clear) begin
            state    <= ST_IDLE;
            count    <= '0;
            mismatch <= 1'b0;
          end else if (launch) begin
            state    <= ST_PLAY;
            rd_ptr   <= '0;
            expected <= '0;
            mismatch <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_cmd_sequencer.sv
// tb/tb_acc_cmd_sequencer.sv - scoreboard bench for acc_cmd_sequencer with a behavioural accumulator
module tb_acc_cmd_sequencer;

  localparam int DEPTH = 8;
  localparam int CW    = 4;

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic          load_valid = 1'b0;
  logic [1:0]    load_op = '0;
  logic [7:0]    load_data = '0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          cmd_ready = 1'b0;
  logic [7:0]    acc_in;
  logic          load_ready;
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [7:0]    cmd_data;
  logic          busy;
  logic          done;
  logic          mismatch;
  logic [CW-1:0] count;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [1:0] prog_op [DEPTH];
  logic [7:0] prog_data [DEPTH];
  int   prog_n = 0;
  logic acc_clr = 1'b1;
  int   acc_idx = 0;
  int   corrupt_idx = -1;

  acc_cmd_sequencer #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .load_valid(load_valid), .load_op(load_op), .load_data(load_data), .load_ready(load_ready),
    .start(start), .clear(clear),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .acc_in(acc_in), .busy(busy), .done(done), .mismatch(mismatch), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [1:0] op, input logic [7:0] d);
    case (op)
      2'd0:    return a + d;
      2'd1:    return a - d;
      2'd2:    return a | d;
      default: return a ^ d;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Accumulator under test: registers its result on the accept edge, optionally corrupted once.
  always @(posedge clk) begin
    if (acc_clr) begin
      acc_in  <= 8'h00;
      acc_idx <= 0;
    end else if (cmd_valid && cmd_ready) begin
      acc_in  <= (acc_idx == corrupt_idx) ? 8'h00 : ref_op(acc_in, cmd_op, cmd_data);
      acc_idx <= acc_idx + 1;
    end
  end

  // Monitor: every accepted command must match the scoreboard; stalled payloads must hold.
  initial begin
    logic       hv;
    logic [1:0] ho;
    logic [7:0] hd;
    exp_t       e;
    hv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && cmd_valid) begin
        if (hv) begin
          chk("hold_op", 32'(cmd_op), 32'(ho));
          chk("hold_data", 32'(cmd_data), 32'(hd));
        end
        if (cmd_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cmd: got op %0d data 0x%0h with empty scoreboard", cmd_op, cmd_data);
          end else begin
            e = exp_q.pop_front();
            chk("cmd_op", 32'(cmd_op), 32'(e.op));
            chk("cmd_data", 32'(cmd_data), 32'(e.data));
          end
          hv = 1'b0;
        end else begin
          hv = 1'b1;
          ho = cmd_op;
          hd = cmd_data;
        end
      end else begin
        hv = 1'b0;
      end
    end
  end

  task automatic do_load(input logic [1:0] op, input logic [7:0] d);
    @(posedge clk); #1;
    load_valid = 1'b1; load_op = op; load_data = d;
    @(posedge clk); #1;
    load_valid = 1'b0;
    if (prog_n < DEPTH) begin
      prog_op[prog_n]   = op;
      prog_data[prog_n] = d;
      prog_n++;
    end
  endtask

  task automatic do_clear();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    prog_n = 0;
    @(negedge clk);
    chk("clear_count", 32'(count), 32'(0));
    chk("clear_load_ready", 32'(load_ready), 32'(1));
    chk("clear_done", 32'(done), 32'(0));
  endtask

  task automatic run(input int stall_pct, input int cidx);
    logic [7:0] g, a;
    logic       mm;
    exp_t       e;
    int         cyc;
    g = 8'h00; a = 8'h00; mm = 1'b0;
    for (int i = 0; i < prog_n; i++) begin
      g = ref_op(g, prog_op[i], prog_data[i]);
      a = (i == cidx) ? 8'h00 : ref_op(a, prog_op[i], prog_data[i]);
      if (a != g) mm = 1'b1;
      e.op = prog_op[i];
      e.data = prog_data[i];
      exp_q.push_back(e);
    end
    corrupt_idx = cidx;
    @(posedge clk); #1 acc_clr = 1'b1;
    @(posedge clk); #1 acc_clr = 1'b0;
    start = 1'b1;
    cmd_ready = (stall_pct == 0) ? 1'b1 : (int'($urandom_range(99)) >= stall_pct);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("start_latency_valid", 32'(cmd_valid), 32'(1));
    chk("start_busy", 32'(busy), 32'(1));
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cmd_ready = (stall_pct == 0) ? 1'b1 : (int'($urandom_range(99)) >= stall_pct);
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 400);
    chk("run_done", 32'(done), 32'(1));
    chk("run_mismatch", 32'(mismatch), 32'(mm));
    chk("run_busy_idle", 32'(busy), 32'(0));
    chk("run_scoreboard_empty", 32'(exp_q.size()), 32'(0));
    chk("done_load_refused", 32'(load_ready), 32'(0));
    if (stall_pct == 0) chk("run_cycles", 32'(cyc), 32'(2 * prog_n));
    cmd_ready = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    ena = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; acc_clr = 1'b0;
    @(negedge clk);
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_cmd_valid", 32'(cmd_valid), 32'(0));
    chk("rst_cmd_op", 32'(cmd_op), 32'(0));
    chk("rst_cmd_data", 32'(cmd_data), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_mismatch", 32'(mismatch), 32'(0));
    chk("rst_load_ready", 32'(load_ready), 32'(1));

    do_load(2'd0, 8'h05);
    do_load(2'd1, 8'h02);
    do_load(2'd3, 8'h0F);
    do_load(2'd2, 8'h30);
    @(negedge clk);
    chk("count_four", 32'(count), 32'(4));
    run(0, -1);
    run(0, 1);
    run(0, -1);
    run(70, -1);
    do_clear();

    do_load(2'd1, 8'h01);
    do_load(2'd0, 8'h02);
    run(0, -1);
    do_clear();

    for (int i = 0; i < 9; i++) do_load(2'($urandom_range(3)), 8'($urandom));
    @(negedge clk);
    chk("full_count", 32'(count), 32'(8));
    chk("full_load_ready", 32'(load_ready), 32'(0));
    run(60, -1);
    do_clear();

    for (int r = 0; r < 8; r++) begin
      int n;
      n = int'($urandom_range(1, DEPTH));
      for (int i = 0; i < n; i++) do_load(2'($urandom_range(3)), 8'($urandom));
      run((r % 2 == 0) ? 0 : 50, (r % 3 == 0) ? int'($urandom_range(n - 1)) : -1);
      do_clear();
    end

    do_load(2'd0, 8'h11);
    do_load(2'd1, 8'h22);
    do_load(2'd2, 8'h33);
    cmd_ready = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.delete();
    prog_n = 0;
    @(negedge clk);
    chk("midrst_count", 32'(count), 32'(0));
    chk("midrst_cmd_valid", 32'(cmd_valid), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    chk("midrst_mismatch", 32'(mismatch), 32'(0));
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("empty_start_busy", 32'(busy), 32'(0));
    chk("empty_start_valid", 32'(cmd_valid), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
